output_phase_ctrl: RTL
======================

Name: output_phase_ctrl

Overview:
Sequencing controller for the FFT output reorder stage. It drives sel_1 of the two-line reorder datapath, which registers line2 and swaps line1 and line2 through a mux pair. It also generates valid strobes aligned to the datapath's I (combinational) and R_reg (registered) outputs, tracks sample index per frame, and flags broken frames. It sits between the last butterfly stage's valid and the downstream output sink.

Parameters:
N, 16, samples per frame on each input line; must be even and >= 2
CNT_W, $clog2(N)+1, width of the in-frame index counter

Ports:
clk  input  1  clock, all flops rising-edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  line1/line2 carry sample k of the current frame this cycle
sel_1  output  1  mux select to the reorder datapath
i_valid  output  1  datapath I output is valid this cycle (combinational from state/index)
r_valid  output  1  datapath R_reg output is valid this cycle (registered)
k_idx  output  CNT_W  in-frame index k of the current cycle (0..N)
busy  output  1  high in RUN or FLUSH
frame_done  output  1  one-cycle pulse in the FLUSH cycle
err  output  1  one-cycle pulse when in_valid drops mid-frame

Behaviour:
- Reset, asynchronous: state=IDLE, k=0, sel_1=0, r_valid=0, err=0, frame_done=0.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - sel_1=0, i_valid=0.
  - in_valid=1 starts a frame with k=0 in this same cycle; next state RUN with k=1.
- RUN with index k, where 0<=k<=N-1:
  - sel_1 = k[0]: even k passes line1 to R and delayed line2 to I; odd k passes delayed line2 to R and line1 to I.
  - i_valid = 1 for k>=1. At k=0 the delayed line2 is stale, so i_valid=0.
  - r_valid is registered and goes high in the cycle after every accepted k.
  - in_valid=1 and k<N-1: k increments.
  - in_valid=1 and k=N-1: next state FLUSH, k=N.
  - in_valid=0 in RUN: err pulses next cycle, state goes to IDLE, k=0, no flush, and no r_valid for the dropped cycle.
- FLUSH, k=N:
  - sel_1=0, i_valid=1 (I = line2 of sample N-1), frame_done=1.
  - in_valid=0: R carries garbage; next cycle r_valid=0; next state IDLE.
  - in_valid=1: back-to-back frame. This cycle is k=0 of the new frame, R=line1(0) is valid, and next state is RUN with k=1.
- Per-frame output totals: exactly N i_valid cycles and N r_valid cycles.
- Latency:
  - I valid from the frame's second accepted cycle through the FLUSH cycle.
  - R_reg valid one cycle after each accepted cycle.
- k_idx reports the current-cycle index: 0 when in IDLE or on a frame start, N in FLUSH.
- Reset asserted mid-frame discards the frame immediately; no frame_done, no err.
- Datapath flops have no enable, so the controller does not stall. A gap inside a frame is always an error.

Optional Feature:
OUTPUT_PHASE_CTRL_ERR_CNT_EN
- Defined:
  - Adds output err_cnt, 8 bits, reset to 0.
  - Increments on each err pulse and saturates at 255.
  - Adds input err_clr, 1 bit. err_clr clears err_cnt synchronously; when err_clr and an err pulse occur in the same cycle, clear wins.
- Undefined: neither port exists, and no counter logic is present.

Test Plan:
- N=4, in_valid high for 4 cycles then low:
  - sel_1 = 0,1,0,1 then 0 (FLUSH).
  - i_valid = 0,1,1,1,1.
  - r_valid = 0,1,1,1,1,0.
  - frame_done pulses on cycle 5 (FLUSH); state returns to IDLE.
- N=4, in_valid high for 8 consecutive cycles:
  - Cycle 5 is FLUSH and also k=0 of frame 2, with sel_1=0 and i_valid=1.
  - Expect 2 frame_done pulses, 8 i_valid cycles and 8 r_valid cycles total.
- N=4, in_valid pattern 1,1,0:
  - err pulses in the cycle after the drop.
  - busy falls; no frame_done.
  - r_valid count is 2.
- N=4, rst asserted during k=2: on the same edge sel_1=0, r_valid=0, busy=0, k_idx=0; no err and no frame_done follow.
- Datapath co-simulation with N=4:
  - line1 = 10,12,14,16 and line2 = 11,13,15,17.
  - R_reg stream under r_valid = 10,11,14,15.
  - I stream under i_valid = 12,13,16,17.
- With OUTPUT_PHASE_CTRL_ERR_CNT_EN: three aborted frames give err_cnt=3; err_clr asserted together with a 4th err gives err_cnt=0.

Source files
------------

// File: rtl/output_phase_ctrl.sv
// Output reorder sequencer: drives sel_1 of the two-line reorder datapath,
// produces I/R_reg valid strobes, tracks in-frame index k and flags broken frames.
// Ports: clk, rst (async, active-high), in_valid -> sel_1, i_valid, r_valid,
//   k_idx, busy, frame_done, err.
// Optional OUTPUT_PHASE_CTRL_ERR_CNT_EN: adds err_clr input and err_cnt[7:0] output.
module output_phase_ctrl #(
  parameter int N     = 16,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             sel_1,
  output logic             i_valid,
  output logic             r_valid,
  output logic [CNT_W-1:0] k_idx,
  output logic             busy,
  output logic             frame_done,
  output logic             err
`ifdef OUTPUT_PHASE_CTRL_ERR_CNT_EN
  ,
  input  logic             err_clr,
  output logic [7:0]       err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_e;

  localparam logic [CNT_W-1:0] K_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] K_N    = CNT_W'(N);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic             r_valid_q, r_valid_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      r_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      r_valid_q <= r_valid_d;
      err_q     <= err_d;
    end
  end

  // k=0 of a frame is never held in RUN: it is either the IDLE start cycle
  // or the FLUSH cycle of the previous frame, so RUN always has k>=1.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    r_valid_d  = 1'b0;
    err_d      = 1'b0;
    sel_1      = 1'b0;
    i_valid    = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    k_idx      = k_q;
    unique case (state_q)
      IDLE: begin
        k_idx = '0;
        if (in_valid) begin
          state_d   = RUN;
          k_d       = K_ONE;
          r_valid_d = 1'b1;
        end
      end
      RUN: begin
        busy    = 1'b1;
        sel_1   = k_q[0];
        i_valid = (k_q != '0);
        if (in_valid) begin
          r_valid_d = 1'b1;
          if (k_q == K_LAST) begin
            state_d = FLUSH;
            k_d     = K_N;
          end else begin
            k_d = k_q + K_ONE;
          end
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
          k_d     = '0;
        end
      end
      FLUSH: begin
        busy       = 1'b1;
        i_valid    = 1'b1;
        frame_done = 1'b1;
        k_idx      = K_N;
        if (in_valid) begin
          // back-to-back frame: this cycle is k=0 of the next one
          state_d   = RUN;
          k_d       = K_ONE;
          r_valid_d = 1'b1;
        end else begin
          state_d = IDLE;
          k_d     = '0;
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  assign r_valid = r_valid_q;
  assign err     = err_q;

`ifdef OUTPUT_PHASE_CTRL_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // clear has priority over a coincident err pulse
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = 8'd0;
    end else if (err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
